control_sequencer: RTL and testbench
====================================

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001: clk  input  1  single system clock; all state updates on rising edge.
REQ-002: clr  input  1  asynchronous, active-high reset.
REQ-003: run  input  1  1 = execute; 0 = programming mode, sequencer frozen.
REQ-004: bus_in  input  8  shared bus; carries the RAM word during instruction fetch.
REQ-005: bus_out  output  4  instruction register operand, IR[3:0].
REQ-006: ir_q  output  8  instruction register contents, for display.
REQ-007: step  output  3  current microstep, T0..T4 encoded 0..4.
REQ-008: Control outputs, each 1 bit, active-high:
- hlt: halt
- mi: MAR load, drives the RAM load_mar_reg
- ro: RAM output enable
- ri: RAM write
- ii: IR load
- io: IR output to bus
- ai / ao: A register in / out
- eo: ALU out
- su: ALU subtract
- bi: B register in
- oi: output register in
- ce: PC count enable
- co: PC out
- j: PC jump

Function
REQ-009: IR SHALL load bus_in on a rising clk edge when ii=1 and run=1, and SHALL otherwise hold its value.
REQ-010: bus_out SHALL equal IR[3:0] at all times; bus drive is qualified externally by io.
REQ-011: The step counter SHALL advance 0→1→2→3→4→0 on each rising clk edge while run=1 and not halted.
- Every instruction is fixed at 5 steps.
- There is no early termination.
REQ-012: Control outputs SHALL be combinational from {step, IR[7:4], halted, run}; any signal not listed for a step SHALL be 0.
REQ-013: Fetch cycle, common to all opcodes:
- T0: co, mi
- T1: ro, ii, ce
REQ-014: Execute steps by opcode IR[7:4] (steps not listed are empty):
- 0001 LDA: T2 io,mi; T3 ro,ai
- 0010 ADD: T2 io,mi; T3 ro,bi; T4 eo,ai
- 0011 SUB: T2 io,mi; T3 ro,bi; T4 eo,ai,su
- 0100 STA: T2 io,mi; T3 ao,ri
- 0101 LDI: T2 io,ai
- 0110 JMP: T2 io,j
- 1110 OUT: T2 ao,oi
- 1111 HLT: T2 hlt
REQ-015: Opcode 0000 and opcodes 0111–1101 SHALL execute as NOP, with T2–T4 empty.
REQ-016: HLT handling:
- At the rising edge ending T2 of HLT, a halted flag SHALL set and step SHALL freeze at 2.
- While halted, only hlt=1 is driven; all other controls are 0.
- The halted state is left only by clr.
REQ-017: While run=0:
- step, IR and halted SHALL hold their values.
- All control outputs SHALL be 0, including hlt.
- When run returns to 1, sequencing resumes from the held step.
REQ-018: At most one bus driver (co, ro, io, ao, eo) SHALL be asserted in any step.
REQ-019: step values 5–7 are unreachable; if entered, the counter SHALL return to 0 on the next enabled edge with all controls 0 during that cycle.

Reset
REQ-020: clr=1 SHALL immediately set step=0, IR=8'h00 and halted=0, independent of clk.
REQ-021: During and after clr with run=1, outputs SHALL be co=1, mi=1 and all others 0, with bus_out=4'h0.
REQ-022: clr asserted in any step, including while halted, SHALL abort the current instruction without completing its remaining steps.
REQ-023: Deassertion of clr SHALL take effect at the next rising clk edge, which advances from T0.

Verification
REQ-024: LDA fetch and execute
- Stimulus: clr pulse, run=1, bus_in=8'h1E, 5 clocks.
- Response: T0 co,mi; T1 ro,ii,ce; ir_q=8'h1E after the T1 edge; T2 io,mi with bus_out=4'hE; T3 ro,ai; T4 empty; step returns to 0.
REQ-025: SUB execute
- Stimulus: IR loaded with 8'h3A.
- Response: T2 io,mi; T3 ro,bi; T4 eo,ai,su; no other controls at T4.
REQ-026: HLT freeze
- Stimulus: IR loaded with 8'hF0, then 10 further clocks.
- Response: step frozen at 2 with hlt=1 and all other controls 0; a clr pulse then restores step=0 with co,mi.
REQ-027: run hold
- Stimulus: run=0 during ADD T3, held 3 clocks.
- Response: step=3, all controls 0, IR unchanged; after run=1, T3 ro,bi, then T4 eo,ai.
REQ-028: asynchronous clear
- Stimulus: clr asserted between clock edges during STA (8'h4C) T3.
- Response: step=0, ir_q=8'h00, ri=0 immediately, before any clock edge.
REQ-029: NOP and undefined opcodes
- Stimulus: IR loaded with 8'h00, then 8'h9F.
- Response: T2–T4 all controls 0; the next fetch starts at T0.

Source files
------------

// File: rtl/control_sequencer.sv
//==============================================================================
// Module      : control_sequencer
// Description : Five-step microcoded control sequencer with instruction
//               register, halt latch and run/programming freeze.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module control_sequencer (
  input  logic       clk,
  input  logic       clr,
  input  logic       run,
  input  logic [7:0] bus_in,
  output logic [3:0] bus_out,
  output logic [7:0] ir_q,
  output logic [2:0] step,
  output logic       hlt,
  output logic       mi,
  output logic       ro,
  output logic       ri,
  output logic       ii,
  output logic       io,
  output logic       ai,
  output logic       ao,
  output logic       eo,
  output logic       su,
  output logic       bi,
  output logic       oi,
  output logic       ce,
  output logic       co,
  output logic       j
);

  typedef enum logic [2:0] {
    T0 = 3'd0,
    T1 = 3'd1,
    T2 = 3'd2,
    T3 = 3'd3,
    T4 = 3'd4
  } step_t;

  localparam logic [3:0] c_OP_LDA = 4'b0001;
  localparam logic [3:0] c_OP_ADD = 4'b0010;
  localparam logic [3:0] c_OP_SUB = 4'b0011;
  localparam logic [3:0] c_OP_STA = 4'b0100;
  localparam logic [3:0] c_OP_LDI = 4'b0101;
  localparam logic [3:0] c_OP_JMP = 4'b0110;
  localparam logic [3:0] c_OP_OUT = 4'b1110;
  localparam logic [3:0] c_OP_HLT = 4'b1111;

  step_t      r_step;
  step_t      w_step_next;
  logic [7:0] r_ir;
  logic       r_halted;
  logic       w_halt_set;
  logic [3:0] w_opcode;

  assign w_opcode = r_ir[7:4];
  assign bus_out  = r_ir[3:0];
  assign ir_q     = r_ir;
  assign step     = r_step;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_step   <= T0;
      r_ir     <= 8'h00;
      r_halted <= 1'b0;
    end else if (run && !r_halted) begin
      r_step <= w_step_next;
      if (w_halt_set) begin
        r_halted <= 1'b1;
      end
      // ii is already qualified by run and not-halted
      if (ii) begin
        r_ir <= bus_in;
      end
    end
  end

  always_comb begin
    w_step_next = T0;
    w_halt_set  = 1'b0;
    hlt = 1'b0; mi = 1'b0; ro = 1'b0; ri = 1'b0; ii = 1'b0;
    io  = 1'b0; ai = 1'b0; ao = 1'b0; eo = 1'b0; su = 1'b0;
    bi  = 1'b0; oi = 1'b0; ce = 1'b0; co = 1'b0; j  = 1'b0;

    case (r_step)
      T0:      w_step_next = T1;
      T1:      w_step_next = T2;
      T2: begin
        if (w_opcode == c_OP_HLT) begin
          w_halt_set  = 1'b1;
          w_step_next = T2;
        end else begin
          w_step_next = T3;
        end
      end
      T3:      w_step_next = T4;
      T4:      w_step_next = T0;
      default: w_step_next = T0;
    endcase

    // Frozen sequencer drives nothing; a halted one drives only hlt
    if (run && r_halted) begin
      hlt = 1'b1;
    end else if (run) begin
      case (r_step)
        T0: begin
          co = 1'b1; mi = 1'b1;
        end
        T1: begin
          ro = 1'b1; ii = 1'b1; ce = 1'b1;
        end
        T2: begin
          case (w_opcode)
            c_OP_LDA, c_OP_ADD, c_OP_SUB, c_OP_STA: begin
              io = 1'b1; mi = 1'b1;
            end
            c_OP_LDI: begin
              io = 1'b1; ai = 1'b1;
            end
            c_OP_JMP: begin
              io = 1'b1; j = 1'b1;
            end
            c_OP_OUT: begin
              ao = 1'b1; oi = 1'b1;
            end
            c_OP_HLT: hlt = 1'b1;
            default: ;
          endcase
        end
        T3: begin
          case (w_opcode)
            c_OP_LDA: begin
              ro = 1'b1; ai = 1'b1;
            end
            c_OP_ADD, c_OP_SUB: begin
              ro = 1'b1; bi = 1'b1;
            end
            c_OP_STA: begin
              ao = 1'b1; ri = 1'b1;
            end
            default: ;
          endcase
        end
        T4: begin
          if (w_opcode == c_OP_ADD || w_opcode == c_OP_SUB) begin
            eo = 1'b1; ai = 1'b1;
            su = (w_opcode == c_OP_SUB);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_control_sequencer.sv
//==============================================================================
// Module      : tb_control_sequencer
// Description : Vector table, directed corner cases and randomized model check
//               for control_sequencer.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_control_sequencer;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic       run = 1'b0;
  logic [7:0] bus_in = 8'h00;
  logic [3:0] bus_out;
  logic [7:0] ir_q;
  logic [2:0] step;
  logic hlt, mi, ro, ri, ii, io, ai, ao, eo, su, bi, oi, ce, co, j;

  control_sequencer dut (
    .clk(clk), .clr(clr), .run(run), .bus_in(bus_in), .bus_out(bus_out),
    .ir_q(ir_q), .step(step), .hlt(hlt), .mi(mi), .ro(ro), .ri(ri), .ii(ii),
    .io(io), .ai(ai), .ao(ao), .eo(eo), .su(su), .bi(bi), .oi(oi), .ce(ce),
    .co(co), .j(j)
  );

  always #5 clk = ~clk;

  localparam logic [14:0] C_HLT = 15'h4000, C_MI = 15'h2000, C_RO = 15'h1000,
                          C_RI  = 15'h0800, C_II = 15'h0400, C_IO = 15'h0200,
                          C_AI  = 15'h0100, C_AO = 15'h0080, C_EO = 15'h0040,
                          C_SU  = 15'h0020, C_BI = 15'h0010, C_OI = 15'h0008,
                          C_CE  = 15'h0004, C_CO = 15'h0002, C_J  = 15'h0001;
  localparam logic [14:0] C_FETCH0 = C_CO | C_MI;
  localparam logic [14:0] C_FETCH1 = C_RO | C_II | C_CE;

  wire [14:0] ctrl = {hlt, mi, ro, ri, ii, io, ai, ao, eo, su, bi, oi, ce, co, j};

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        run;
    logic [7:0]  bus;
    logic [2:0]  st;
    logic [7:0]  ir;
    logic [14:0] c;
  } vec_t;

  vec_t vecs[$];

  // Microcode for execute steps T2..T4, indexed by opcode
  logic [14:0] ucode [16][3];

  int         m_step;
  logic [7:0] m_ir;
  bit         m_halted;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic [2:0] st, input logic [7:0] ir,
                         input logic [14:0] c);
    chk({tag, ".step"}, {13'd0, step}, {13'd0, st});
    chk({tag, ".ir_q"}, {8'd0, ir_q}, {8'd0, ir});
    chk({tag, ".bus_out"}, {12'd0, bus_out}, {12'd0, ir[3:0]});
    chk({tag, ".ctrl"}, {1'b0, ctrl}, {1'b0, c});
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_clr;
    #1 clr = 1'b1;
    #1 clr = 1'b0;
  endtask

  task automatic add_vec(input logic r, input logic [7:0] b, input logic [2:0] s,
                         input logic [7:0] ir, input logic [14:0] c);
    vec_t v;
    v.run = r; v.bus = b; v.st = s; v.ir = ir; v.c = c;
    vecs.push_back(v);
  endtask

  // One full five-step instruction, starting with prev_ir in IR
  task automatic add_instr(input logic [7:0] prev_ir, input logic [7:0] op_ir,
                           input logic [14:0] e2, input logic [14:0] e3,
                           input logic [14:0] e4);
    add_vec(1'b1, op_ir, 3'd0, prev_ir, C_FETCH0);
    add_vec(1'b1, op_ir, 3'd1, prev_ir, C_FETCH1);
    add_vec(1'b1, 8'h00, 3'd2, op_ir, e2);
    add_vec(1'b1, 8'h00, 3'd3, op_ir, e3);
    add_vec(1'b1, 8'h00, 3'd4, op_ir, e4);
  endtask

  function automatic logic [14:0] exp_ctrl(input int st, input logic [7:0] ir,
                                           input bit halted, input logic r);
    if (!r)        return 15'h0;
    if (halted)    return C_HLT;
    if (st == 0)   return C_FETCH0;
    if (st == 1)   return C_FETCH1;
    if (st > 4)    return 15'h0;
    return ucode[ir[7:4]][st-2];
  endfunction

  initial begin
    for (int o = 0; o < 16; o++)
      for (int s = 0; s < 3; s++) ucode[o][s] = 15'h0;
    ucode[1]  = '{C_IO | C_MI, C_RO | C_AI, 15'h0};
    ucode[2]  = '{C_IO | C_MI, C_RO | C_BI, C_EO | C_AI};
    ucode[3]  = '{C_IO | C_MI, C_RO | C_BI, C_EO | C_AI | C_SU};
    ucode[4]  = '{C_IO | C_MI, C_AO | C_RI, 15'h0};
    ucode[5]  = '{C_IO | C_AI, 15'h0, 15'h0};
    ucode[6]  = '{C_IO | C_J, 15'h0, 15'h0};
    ucode[14] = '{C_AO | C_OI, 15'h0, 15'h0};
    ucode[15] = '{C_HLT, 15'h0, 15'h0};

    // Program table: LDA, SUB, LDI, OUT, JMP, STA, NOP, undefined, HLT freeze
    add_instr(8'h00, 8'h1E, C_IO | C_MI, C_RO | C_AI, 15'h0);
    add_instr(8'h1E, 8'h3A, C_IO | C_MI, C_RO | C_BI, C_EO | C_AI | C_SU);
    add_instr(8'h3A, 8'h57, C_IO | C_AI, 15'h0, 15'h0);
    add_instr(8'h57, 8'hE0, C_AO | C_OI, 15'h0, 15'h0);
    add_instr(8'hE0, 8'h65, C_IO | C_J, 15'h0, 15'h0);
    add_instr(8'h65, 8'h4C, C_IO | C_MI, C_AO | C_RI, 15'h0);
    add_instr(8'h4C, 8'h00, 15'h0, 15'h0, 15'h0);
    add_instr(8'h00, 8'h9F, 15'h0, 15'h0, 15'h0);
    add_vec(1'b1, 8'hF0, 3'd0, 8'h9F, C_FETCH0);
    add_vec(1'b1, 8'hF0, 3'd1, 8'h9F, C_FETCH1);
    for (int k = 0; k < 11; k++) add_vec(1'b1, 8'hAA, 3'd2, 8'hF0, C_HLT);
    add_vec(1'b0, 8'hAA, 3'd2, 8'hF0, 15'h0);
    add_vec(1'b1, 8'hAA, 3'd2, 8'hF0, C_HLT);

    // Reset state, checked while clr is still asserted
    run = 1'b1;
    clr = 1'b1;
    #2;
    chk_all("reset", 3'd0, 8'h00, C_FETCH0);
    clr = 1'b0;

    foreach (vecs[i]) begin
      run    = vecs[i].run;
      bus_in = vecs[i].bus;
      #1;
      chk_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].ir, vecs[i].c);
      tick();
    end

    // clr releases the halt
    run = 1'b1;
    pulse_clr();
    chk_all("halt_clr", 3'd0, 8'h00, C_FETCH0);

    // run hold in ADD T3
    bus_in = 8'h2B;
    tick();
    chk_all("add_t1", 3'd1, 8'h00, C_FETCH1);
    tick();
    bus_in = 8'h77;
    chk_all("add_t2", 3'd2, 8'h2B, C_IO | C_MI);
    tick();
    run = 1'b0;
    #1;
    chk_all("hold_t3", 3'd3, 8'h2B, 15'h0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_all("hold", 3'd3, 8'h2B, 15'h0);
    end
    run = 1'b1;
    #1;
    chk_all("resume_t3", 3'd3, 8'h2B, C_RO | C_BI);
    tick();
    chk_all("resume_t4", 3'd4, 8'h2B, C_EO | C_AI);
    tick();
    chk_all("resume_t0", 3'd0, 8'h2B, C_FETCH0);

    // Asynchronous clear in STA T3
    bus_in = 8'h4C;
    tick(); tick(); tick();
    chk_all("sta_t3", 3'd3, 8'h4C, C_AO | C_RI);
    #1 clr = 1'b1;
    #1;
    chk_all("async_clr", 3'd0, 8'h00, C_FETCH0);
    clr = 1'b0;
    tick();
    chk_all("after_clr", 3'd1, 8'h00, C_FETCH1);

    // Randomized run against the reference model
    pulse_clr();
    m_step = 0; m_ir = 8'h00; m_halted = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      run    = ($urandom_range(0, 9) != 0);
      bus_in = 8'($urandom);
      if ($urandom_range(0, 29) == 0) begin
        pulse_clr();
        m_step = 0; m_ir = 8'h00; m_halted = 1'b0;
      end
      #1;
      chk("rnd.step", {13'd0, step}, 16'(m_step));
      chk("rnd.ir_q", {8'd0, ir_q}, {8'd0, m_ir});
      chk("rnd.bus_out", {12'd0, bus_out}, {12'd0, m_ir[3:0]});
      chk("rnd.ctrl", {1'b0, ctrl}, {1'b0, exp_ctrl(m_step, m_ir, m_halted, run)});
      chk("rnd.one_driver", 16'(int'(co) + int'(ro) + int'(io) + int'(ao) + int'(eo) > 1), 16'd0);
      @(posedge clk);
      if (run && !m_halted) begin
        if (m_step == 1) m_ir = bus_in;
        if (m_step == 2 && m_ir[7:4] == 4'hF) m_halted = 1'b1;
        else m_step = (m_step + 1) % 5;
      end
      #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
